blake_round_seq: RTL and testbench

//  Parametrised round/step sequencer for the BLAKE-512 compression core; successor to the flat 7-bit step counter.

---
 rtl/blake_round_seq_if.sv | 35 +++
 rtl/blake_round_seq.sv | 133 +++++++++++++
 tb/tb_blake_round_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/blake_round_seq_if.sv
// Handshake and index bus between the BLAKE-512 core controller (master)
// and the round/step sequencer (slave). Widths follow the sequencer parameters.
interface blake_round_seq_if #(
   parameter int ROUNDS    = 16,
   parameter int STEPS     = 8,
   parameter int SIGMA_MOD = 10
);
   localparam int RW = (ROUNDS    > 1) ? $clog2(ROUNDS)    : 1;
   localparam int SW = (STEPS     > 1) ? $clog2(STEPS)     : 1;
   localparam int GW = (SIGMA_MOD > 1) ? $clog2(SIGMA_MOD) : 1;

   logic             start;
   logic             stall;
   logic             abort;
   logic             busy;
   logic [RW-1:0]    round_idx;
   logic [SW-1:0]    step_idx;
   logic [RW+SW-1:0] flat_idx;
   logic [GW-1:0]    sigma_idx;
   logic             first_step;
   logic             last_step;
   logic             done;

   modport master (
      output start, stall, abort,
      input  busy, round_idx, step_idx, flat_idx, sigma_idx,
             first_step, last_step, done
   );

   modport slave (
      input  start, stall, abort,
      output busy, round_idx, step_idx, flat_idx, sigma_idx,
             first_step, last_step, done
   );
endinterface

// File: rtl/blake_round_seq.sv
// Round / G-step sequencer for the BLAKE-512 compression core.
// Walks ROUNDS x STEPS G-steps after a start request, tracks the sigma row
// with its own modulo counter, supports stall and abort, and pulses done
// for one cycle after the final step. Every output is decoded from registers.
module blake_round_seq #(
   parameter int ROUNDS    = 16,
   parameter int STEPS     = 8,
   parameter int SIGMA_MOD = 10
) (
   input  logic                 clk,
   input  logic                 rstb,
   blake_round_seq_if.slave     bus
);
   localparam int RW = (ROUNDS    > 1) ? $clog2(ROUNDS)    : 1;
   localparam int SW = (STEPS     > 1) ? $clog2(STEPS)     : 1;
   localparam int GW = (SIGMA_MOD > 1) ? $clog2(SIGMA_MOD) : 1;
   localparam int FW = RW + SW;

   localparam logic [RW-1:0] LP_ROUND_LAST = RW'(ROUNDS - 1);
   localparam logic [SW-1:0] LP_STEP_LAST  = SW'(STEPS - 1);
   localparam logic [GW-1:0] LP_SIGMA_LAST = GW'(SIGMA_MOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [RW-1:0] r_round;
   logic [RW-1:0] w_round_nxt;
   logic [SW-1:0] r_step;
   logic [SW-1:0] w_step_nxt;
   logic [GW-1:0] r_sigma;
   logic [GW-1:0] w_sigma_nxt;
   logic          w_run;
   logic          w_step_wrap;
   logic          w_last;

   assign w_run       = (r_state == ST_RUN);
   assign w_step_wrap = (r_step == LP_STEP_LAST);
   assign w_last      = w_run && (r_round == LP_ROUND_LAST) && w_step_wrap;

   // State and index registers; async reset returns everything to idle zeros.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state <= ST_IDLE;
         r_round <= {RW{1'b0}};
         r_step  <= {SW{1'b0}};
         r_sigma <= {GW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
         r_step  <= w_step_nxt;
         r_sigma <= w_sigma_nxt;
      end
   end

   // Next-state and index update; abort has priority over start and stall.
   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      w_step_nxt  = r_step;
      w_sigma_nxt = r_sigma;
      if (bus.abort) begin
         w_state_nxt = ST_IDLE;
         w_round_nxt = {RW{1'b0}};
         w_step_nxt  = {SW{1'b0}};
         w_sigma_nxt = {GW{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_round_nxt = {RW{1'b0}};
               w_step_nxt  = {SW{1'b0}};
               w_sigma_nxt = {GW{1'b0}};
               if (bus.start) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (bus.stall) begin
                  w_state_nxt = ST_RUN;
               end else if (w_last) begin
                  w_state_nxt = ST_DONE;
                  w_round_nxt = {RW{1'b0}};
                  w_step_nxt  = {SW{1'b0}};
                  w_sigma_nxt = {GW{1'b0}};
               end else if (w_step_wrap) begin
                  w_step_nxt  = {SW{1'b0}};
                  w_round_nxt = r_round + RW'(1);
                  if (r_sigma == LP_SIGMA_LAST) begin
                     w_sigma_nxt = {GW{1'b0}};
                  end else begin
                     w_sigma_nxt = r_sigma + GW'(1);
                  end
               end else begin
                  w_step_nxt = r_step + SW'(1);
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_IDLE;
               w_round_nxt = {RW{1'b0}};
               w_step_nxt  = {SW{1'b0}};
               w_sigma_nxt = {GW{1'b0}};
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_round_nxt = {RW{1'b0}};
               w_step_nxt  = {SW{1'b0}};
               w_sigma_nxt = {GW{1'b0}};
            end
         endcase
      end
   end

   assign bus.busy       = w_run;
   assign bus.done       = (r_state == ST_DONE);
   assign bus.round_idx  = r_round;
   assign bus.step_idx   = r_step;
   assign bus.sigma_idx  = r_sigma;
   assign bus.first_step = w_run && (r_round == {RW{1'b0}}) && (r_step == {SW{1'b0}});
   assign bus.last_step  = w_last;

   // A power-of-two step count makes the flat index a plain concatenation.
   if (STEPS == (1 << SW)) begin : g_flat_cat
      assign bus.flat_idx = {r_round, r_step};
   end else begin : g_flat_mul
      assign bus.flat_idx = FW'(r_round) * FW'(STEPS) + FW'(r_step);
   end
endmodule

// File: tb/tb_blake_round_seq.sv
// Bench for blake_round_seq: a default 16x8 instance and a 14x6 instance,
// both checked every cycle against a flat-counter reference model through
// a scoreboard queue, plus table-driven scenarios and directed corner cases.
module tb_blake_round_seq;
   logic clk;
   logic rstb;

   blake_round_seq_if #(.ROUNDS(16), .STEPS(8), .SIGMA_MOD(10)) if0 ();
   blake_round_seq_if #(.ROUNDS(14), .STEPS(6), .SIGMA_MOD(10)) if1 ();

   blake_round_seq #(.ROUNDS(16), .STEPS(8), .SIGMA_MOD(10)) dut0 (
      .clk  (clk),
      .rstb (rstb),
      .bus  (if0)
   );

   blake_round_seq #(.ROUNDS(14), .STEPS(6), .SIGMA_MOD(10)) dut1 (
      .clk  (clk),
      .rstb (rstb),
      .bus  (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int busy, round, step, flat, sigma, first, last, done;
   } exp_t;

   typedef struct {
      int sa_at, sa_len, sb_at, sb_len, ab_at, ab_start, exp_lat;
   } row_t;

   exp_t q0[$];
   exp_t q1[$];
   int   m0_st, m0_k, m1_st, m1_k;
   int   total, bad, cyc;

   // Reference: state 0 idle, 1 run, 2 done; k is the flat step number.
   function automatic exp_t model_out(int st, int k, int R, int S, int G);
      exp_t e;
      e = '{default: 0};
      if (st == 1) begin
         e.busy  = 1;
         e.round = k / S;
         e.step  = k % S;
         e.flat  = k;
         e.sigma = (k / S) % G;
         e.first = (k == 0) ? 1 : 0;
         e.last  = (k == R * S - 1) ? 1 : 0;
      end
      e.done = (st == 2) ? 1 : 0;
      return e;
   endfunction

   task automatic model_next(inout int st, inout int k,
                             input logic start, input logic stall, input logic abort,
                             input int R, input int S);
      if (abort) begin
         st = 0; k = 0;
      end else if (st == 0) begin
         st = start ? 1 : 0; k = 0;
      end else if (st == 1) begin
         if (!stall) begin
            if (k == R * S - 1) begin st = 2; k = 0; end
            else k = k + 1;
         end
      end else begin
         st = 0; k = 0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input int exp_v);
      total++;
      if (act !== 32'(exp_v)) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp_v);
      end
   endtask

   task automatic cmp0(input exp_t e);
      chk("d0.busy",  32'(if0.busy),       e.busy);
      chk("d0.round", 32'(if0.round_idx),  e.round);
      chk("d0.step",  32'(if0.step_idx),   e.step);
      chk("d0.flat",  32'(if0.flat_idx),   e.flat);
      chk("d0.sigma", 32'(if0.sigma_idx),  e.sigma);
      chk("d0.first", 32'(if0.first_step), e.first);
      chk("d0.last",  32'(if0.last_step),  e.last);
      chk("d0.done",  32'(if0.done),       e.done);
   endtask

   task automatic cmp1(input exp_t e);
      chk("d1.busy",  32'(if1.busy),       e.busy);
      chk("d1.round", 32'(if1.round_idx),  e.round);
      chk("d1.step",  32'(if1.step_idx),   e.step);
      chk("d1.flat",  32'(if1.flat_idx),   e.flat);
      chk("d1.sigma", 32'(if1.sigma_idx),  e.sigma);
      chk("d1.first", 32'(if1.first_step), e.first);
      chk("d1.last",  32'(if1.last_step),  e.last);
      chk("d1.done",  32'(if1.done),       e.done);
   endtask

   // One clock: predict from current inputs, push, clock, then pop and compare.
   task automatic tick();
      exp_t e;
      model_next(m0_st, m0_k, if0.start, if0.stall, if0.abort, 16, 8);
      q0.push_back(model_out(m0_st, m0_k, 16, 8, 10));
      model_next(m1_st, m1_k, if1.start, if1.stall, if1.abort, 14, 6);
      q1.push_back(model_out(m1_st, m1_k, 14, 6, 10));
      @(posedge clk);
      #1;
      cyc++;
      e = q0.pop_front();
      cmp0(e);
      e = q1.pop_front();
      cmp1(e);
   endtask

   task automatic run_row(input row_t r);
      int lat, sa_rem, sb_rem, maxsig;
      bit sa_hit, sb_hit;
      lat = -1; sa_rem = 0; sb_rem = 0; maxsig = 0; sa_hit = 1'b0; sb_hit = 1'b0;
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      for (int n = 2; n <= 140; n++) begin
         if0.start = 1'b0;
         if0.stall = 1'b0;
         if0.abort = 1'b0;
         if (m0_st == 1) begin
            if (!sa_hit && m0_k == r.sa_at) begin sa_rem = r.sa_len; sa_hit = 1'b1; end
            if (!sb_hit && m0_k == r.sb_at) begin sb_rem = r.sb_len; sb_hit = 1'b1; end
            if (sa_rem > 0) begin if0.stall = 1'b1; sa_rem--; end
            else if (sb_rem > 0) begin if0.stall = 1'b1; sb_rem--; end
            if (m0_k == r.ab_at) begin
               if0.abort = 1'b1;
               if0.start = r.ab_start[0];
            end
         end
         tick();
         if (int'(if0.sigma_idx) > maxsig) maxsig = int'(if0.sigma_idx);
         if (if0.done === 1'b1 && lat < 0) lat = n;
      end
      if0.start = 1'b0; if0.stall = 1'b0; if0.abort = 1'b0;
      chk("d0.latency", 32'(lat), r.exp_lat);
      if (r.exp_lat > 0) chk("d0.sigma_max", 32'(maxsig), 9);
   endtask

   row_t rows[5];
   int   dn_cnt, d1n, d2n, lat1, max_step, max_round;

   initial begin
      total = 0; bad = 0; cyc = 0;
      m0_st = 0; m0_k = 0; m1_st = 0; m1_k = 0;
      rows[0] = '{sa_at: -1, sa_len: 0, sb_at: -1,  sb_len: 0, ab_at: -1, ab_start: 0, exp_lat: 129};
      rows[1] = '{sa_at: 40, sa_len: 3, sb_at: 127, sb_len: 2, ab_at: -1, ab_start: 0, exp_lat: 134};
      rows[2] = '{sa_at: -1, sa_len: 0, sb_at: -1,  sb_len: 0, ab_at: 60, ab_start: 1, exp_lat: -1};
      rows[3] = '{sa_at: -1, sa_len: 0, sb_at: -1,  sb_len: 0, ab_at: -1, ab_start: 0, exp_lat: 129};
      rows[4] = '{sa_at: 0,  sa_len: 1, sb_at: 7,   sb_len: 2, ab_at: -1, ab_start: 0, exp_lat: 132};

      rstb = 1'b0;
      if0.start = 1'b0; if0.stall = 1'b0; if0.abort = 1'b0;
      if1.start = 1'b0; if1.stall = 1'b0; if1.abort = 1'b0;
      #3;
      cmp0(model_out(0, 0, 16, 8, 10));
      cmp1(model_out(0, 0, 14, 6, 10));
      @(negedge clk);
      rstb = 1'b1;
      tick();

      // Abort beats start in IDLE; stall alone in IDLE does nothing.
      if0.start = 1'b1; if0.abort = 1'b1;
      tick();
      if0.start = 1'b0; if0.abort = 1'b0; if0.stall = 1'b1;
      tick();
      if0.stall = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_row(rows[i]);

      // Start held high: runs repeat with a DONE and an IDLE cycle between.
      dn_cnt = 0; d1n = -1; d2n = -1;
      if0.start = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         tick();
         if (if0.done === 1'b1) begin
            dn_cnt++;
            if (d1n < 0) d1n = n;
            else if (d2n < 0) d2n = n;
         end
      end
      if0.start = 1'b0;
      chk("d0.b2b_count", 32'(dn_cnt), 3);
      chk("d0.b2b_first", 32'(d1n), 129);
      chk("d0.b2b_gap", 32'(d2n - d1n), 130);
      if0.abort = 1'b1;
      tick();
      if0.abort = 1'b0;
      tick();

      // Non-power-of-two geometry: 14 rounds of 6 steps.
      lat1 = -1; max_step = 0; max_round = 0;
      if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      for (int n = 2; n <= 100; n++) begin
         tick();
         if (int'(if1.step_idx) > max_step) max_step = int'(if1.step_idx);
         if (int'(if1.round_idx) > max_round) max_round = int'(if1.round_idx);
         if (if1.done === 1'b1 && lat1 < 0) lat1 = n;
      end
      chk("d1.latency", 32'(lat1), 85);
      chk("d1.step_max", 32'(max_step), 5);
      chk("d1.round_max", 32'(max_round), 13);

      // Async reset in the middle of a run clears outputs without a clock edge.
      if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      for (int n = 0; n < 30; n++) tick();
      chk("d1.midrun_busy", 32'(if1.busy), 1);
      #2;
      rstb = 1'b0;
      #1;
      m0_st = 0; m0_k = 0; m1_st = 0; m1_k = 0;
      cmp0(model_out(0, 0, 16, 8, 10));
      cmp1(model_out(0, 0, 14, 6, 10));
      @(negedge clk);
      rstb = 1'b1;
      for (int n = 0; n < 100; n++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
